// File: rtl/spi_flash_arb.sv
// Two-requester SPI flash read arbiter: round-robin grant, then a mode-0
// 0x03 read burst of len+1 bytes, followed by a CS-high guard gap.
module spi_flash_arb #(
   parameter int CLK_DIV = 2,
   parameter int LEN_W   = 8
) (
   input  logic             clk_50MHz,
   input  logic             rst,
   input  logic             scrollEn,
   input  logic             hw_req,
   input  logic             sw_req,
   input  logic [23:0]      hw_addr,
   input  logic [23:0]      sw_addr,
   input  logic [LEN_W-1:0] hw_len,
   input  logic [LEN_W-1:0] sw_len,
   output logic             hw_gnt,
   output logic             sw_gnt,
   output logic [7:0]       rdata,
   output logic             hw_rvalid,
   output logic             sw_rvalid,
   output logic             hw_done,
   output logic             sw_done,
   output logic             busy,
   output logic             SPI_CLK,
   output logic             SPI_CS,
   output logic             SPI_MOSI,
   input  logic             SPI_MISO
);

   localparam int BW = LEN_W + 6;
   localparam logic [4:0] HALF  = 5'(CLK_DIV - 1);
   localparam logic [4:0] GAP_N = 5'(2 * CLK_DIV - 1);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, GAP} state_t;

   state_t          state_q;
   logic            arm_q;
   logic            last_hw_q;
   logic            owner_hw_q;
   logic            busy_q;
   logic            cs_q;
   logic            sclk_q;
   logic            tail_q;
   logic            byte_q;
   logic [4:0]      cnt_q;
   logic [BW-1:0]   bit_q;
   logic [BW-1:0]   last_bit_q;
   logic [31:0]     tx_q;
   logic [7:0]      rx_q;
   logic [7:0]      rdata_q;
   logic            hw_gnt_q, sw_gnt_q;
   logic            hw_rvalid_q, sw_rvalid_q;
   logic            hw_done_q, sw_done_q;

   logic             hw_eff_d;
   logic             any_req_d;
   logic             pick_hw_d;
   logic [23:0]      addr_d;
   logic [LEN_W-1:0] len_d;

   // hw only takes a tie when sw was the last owner
   always_comb begin
      hw_eff_d  = hw_req & scrollEn;
      any_req_d = hw_eff_d | sw_req;
      pick_hw_d = hw_eff_d & (~sw_req | ~last_hw_q);
      addr_d    = pick_hw_d ? hw_addr : sw_addr;
      len_d     = pick_hw_d ? hw_len : sw_len;
   end

   always_ff @(posedge clk_50MHz or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         arm_q       <= 1'b0;
         last_hw_q   <= 1'b0;
         owner_hw_q  <= 1'b0;
         busy_q      <= 1'b0;
         cs_q        <= 1'b1;
         sclk_q      <= 1'b0;
         tail_q      <= 1'b0;
         byte_q      <= 1'b0;
         cnt_q       <= '0;
         bit_q       <= '0;
         last_bit_q  <= '0;
         tx_q        <= '0;
         rx_q        <= '0;
         rdata_q     <= '0;
         hw_gnt_q    <= 1'b0;
         sw_gnt_q    <= 1'b0;
         hw_rvalid_q <= 1'b0;
         sw_rvalid_q <= 1'b0;
         hw_done_q   <= 1'b0;
         sw_done_q   <= 1'b0;
      end else begin
         arm_q       <= 1'b1;
         hw_gnt_q    <= 1'b0;
         sw_gnt_q    <= 1'b0;
         hw_rvalid_q <= 1'b0;
         sw_rvalid_q <= 1'b0;
         hw_done_q   <= 1'b0;
         sw_done_q   <= 1'b0;

         if (byte_q) begin
            byte_q      <= 1'b0;
            rdata_q     <= rx_q;
            hw_rvalid_q <= owner_hw_q;
            sw_rvalid_q <= ~owner_hw_q;
         end

         case (state_q)
            IDLE: begin
               // arm_q keeps the first edge after reset release grant-free
               if (arm_q && any_req_d) begin
                  owner_hw_q <= pick_hw_d;
                  last_hw_q  <= pick_hw_d;
                  hw_gnt_q   <= pick_hw_d;
                  sw_gnt_q   <= ~pick_hw_d;
                  busy_q     <= 1'b1;
                  cs_q       <= 1'b0;
                  sclk_q     <= 1'b0;
                  tail_q     <= 1'b0;
                  cnt_q      <= '0;
                  bit_q      <= '0;
                  last_bit_q <= (BW'(len_d) << 3) + BW'(39);
                  tx_q       <= {8'h03, addr_d};
                  state_q    <= CMD;
               end
            end
            CMD, ADDR, DATA: begin
               if (cnt_q == HALF) begin
                  cnt_q <= '0;
                  if (tail_q) begin
                     tail_q    <= 1'b0;
                     cs_q      <= 1'b1;
                     hw_done_q <= owner_hw_q;
                     sw_done_q <= ~owner_hw_q;
                     state_q   <= GAP;
                  end else if (!sclk_q) begin
                     sclk_q <= 1'b1;
                     rx_q   <= {rx_q[6:0], SPI_MISO};
                     if (bit_q >= BW'(32) && bit_q[2:0] == 3'd7)
                        byte_q <= 1'b1;
                  end else begin
                     sclk_q <= 1'b0;
                     if (bit_q == last_bit_q) begin
                        tail_q <= 1'b1;
                     end else begin
                        bit_q <= bit_q + BW'(1);
                        // zeros shift in behind the address, so MOSI idles low in DATA
                        tx_q  <= tx_q << 1;
                        if (bit_q == BW'(7))
                           state_q <= ADDR;
                        if (bit_q == BW'(31))
                           state_q <= DATA;
                     end
                  end
               end else begin
                  cnt_q <= cnt_q + 5'd1;
               end
            end
            GAP: begin
               busy_q <= 1'b0;
               if (cnt_q == GAP_N) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 5'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign hw_gnt    = hw_gnt_q;
   assign sw_gnt    = sw_gnt_q;
   assign rdata     = rdata_q;
   assign hw_rvalid = hw_rvalid_q;
   assign sw_rvalid = sw_rvalid_q;
   assign hw_done   = hw_done_q;
   assign sw_done   = sw_done_q;
   assign busy      = busy_q;
   assign SPI_CLK   = sclk_q;
   assign SPI_CS    = cs_q;
   assign SPI_MOSI  = tx_q[31];

endmodule

// File: doc/spi_flash_arb.md
SPI_FLASH_ARB -- requirements
Module: spi_flash_arb

Interface
REQ-001 Parameter CLK_DIV, default 2: SPI_CLK half-period in clk_50MHz cycles; legal values are 1 to 15.
REQ-002 Parameter LEN_W, default 8: width of the burst-length fields; a burst transfers len+1 bytes.
REQ-003 clk_50MHz  in  1  the single system clock; every flop is clocked on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 scrollEn  in  1  1 = hardware requester enabled; 0 = hw_req is masked.
REQ-006 hw_req, sw_req  in  1 each  request levels, held until the matching done pulse.
REQ-007 hw_addr, sw_addr  in  24 each  flash byte address.
REQ-008 hw_len, sw_len  in  LEN_W each  byte count minus one.
REQ-009 hw_gnt, sw_gnt  out  1 each  one-cycle pulse when the transfer starts.
REQ-010 rdata  out  8  read byte, shared by both requesters.
REQ-011 hw_rvalid, sw_rvalid  out  1 each  one-cycle pulse when rdata is valid for that owner.
REQ-012 hw_done, sw_done  out  1 each  one-cycle pulse at end of burst.
REQ-013 busy  out  1  high from grant through done inclusive.
REQ-014 SPI_CLK, SPI_CS, SPI_MOSI  out  1 each  flash pins; SPI_MISO  in  1.

Function
REQ-015 FSM states: IDLE, CMD, ADDR, DATA, GAP.
- IDLE: CS high, CLK low.
- CMD: 8 bits, fixed 0x03.
- ADDR: 24 bits, MSB first.
- DATA: 8*(len+1) bits.
- GAP: CS high for 2*CLK_DIV cycles, then IDLE.
REQ-016 Arbitration in IDLE, using effective requests hw_req&scrollEn and sw_req.
- Only one requesting: that one wins.
- Both requesting: round-robin; the winner is the one not granted last.
- Last-owner pointer resets to "sw", so hw wins the first tie.
REQ-017 Grant timing: request high in IDLE at edge t -> gnt pulse, busy=1, SPI_CS=0 and state CMD all take effect at edge t+1.
REQ-018 Address, length and owner are latched at grant; later changes to addr, len or req are ignored until done.
REQ-019 SPI signalling: mode 0; SPI_CLK idles low and toggles every CLK_DIV cycles while state is CMD, ADDR or DATA.
REQ-020 SPI_MOSI is updated on the clk_50MHz edge that drives SPI_CLK low (and at CS assertion for bit 0).
REQ-021 SPI_MOSI is 0 during DATA.
REQ-022 SPI_MISO is sampled on the edge that drives SPI_CLK high, shifted MSB first.
REQ-023 Byte delivery: after the 8th sample of each data byte, rdata is updated and the owner's rvalid pulses on the next cycle.
- rdata holds its value until the next byte.
REQ-024 Burst end: after the last byte, SPI_CLK stays low for CLK_DIV cycles.
- SPI_CS then rises, done pulses for the owner in that same cycle, and state enters GAP.
- busy falls on the following cycle.
REQ-025 Burst length is fixed at grant: a requester dropping req mid-burst does not abort, and a scrollEn change mid-burst does not abort.
REQ-026 Arbitration wrap: the bit counter covers 8+24+8*2^LEN_W bits without overflow, so len = all-ones transfers 2^LEN_W bytes.
REQ-027 Back-to-back requests: a request held through done is re-arbitrated in IDLE after GAP, so the minimum CS-high time is 2*CLK_DIV+1 cycles.
REQ-028 Requests from the non-owner during a burst are held pending and serviced next (round-robin).

Reset
REQ-029 While rst=1, at any time including mid-burst:
- SPI_CS=1, SPI_CLK=0, SPI_MOSI=0.
- All gnt/rvalid/done=0, busy=0, rdata=0x00.
- State=IDLE, last-owner pointer=sw.
REQ-030 The first grant after rst falls occurs no earlier than the second clock edge.

Verification
REQ-031 Single hw read: scrollEn=1, hw_req with addr 0x012345 and len 0; flash model returns 0xA5. Required response:
- MOSI bitstream 0x03 0x01 0x23 0x45.
- rdata=0xA5 with a hw_rvalid pulse.
- hw_done pulse, SPI_CLK edge count 80 (40 pulses), CS low for 40*2*CLK_DIV+CLK_DIV cycles.
REQ-032 Tie: hw_req and sw_req rise in the same cycle with scrollEn=1. Required grant order: hw, then sw, then hw, with each requester kept asserted.
REQ-033 Masking: scrollEn=0 with hw_req and sw_req high. Required response: only sw is granted, repeatedly; hw_gnt never pulses.
REQ-034 Burst: sw_len=3, flash returns 0x10, 0x11, 0x12, 0x13. Required response: four sw_rvalid pulses with those values in order, then one sw_done.
REQ-035 Reset mid-burst: rst asserted during ADDR. Required response:
- CS rises and CLK goes low immediately (asynchronously).
- No done pulse.
- After rst is released, a pending request gets a fresh grant starting with command 0x03.
REQ-036 Address stability: hw_addr changes from 0x000100 to 0x0FFFFF one cycle after hw_gnt. Required response: the transmitted address remains 0x000100.
